pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the pipelined MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It generalises the plain always-latching stage register: it adds a valid/ready handshake, stall back-pressure, synchronous flush (bubble injection), an optional skid buffer for full throughput, and a saturating stall-cycle counter. Control and datapath fields are carried as two packed buses whose widths are set per stage.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers:
// per-stage bus widths, field bit offsets inside the packed ctrl/data
// buses, and the skid-buffer state encoding.
package pipe_pkg;

  // Per-stage bus widths
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;   // instr, pc_plus_4
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 256;
  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = 160;
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 101;

  // Control bus bit positions
  localparam int CTRL_WE_REG = 0;
  localparam int CTRL_WE_DM  = 1;
  localparam int CTRL_DM2REG = 2;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_JUMP   = 4;
  localparam int CTRL_ALUSRC = 5;
  localparam int CTRL_REGDST = 6;
  localparam int CTRL_ALUOP  = 7;   // 3 bits
  localparam int CTRL_JR     = 10;
  localparam int CTRL_JAL    = 11;

  // Datapath bus LSB positions (32-bit fields except rf_wa)
  localparam int DATA_PC4_LSB   = 0;
  localparam int DATA_BTA_LSB   = 32;
  localparam int DATA_ALU_LSB   = 64;
  localparam int DATA_WD_DM_LSB = 96;
  localparam int DATA_RF_WA_LSB = 128;  // 5 bits

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), inc (count request), clr (sync clear,
// wins over inc), cnt (current value, sticks at all-ones).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush
// (bubble injection), optional two-entry skid buffer and a saturating
// stall-cycle counter.
// Ports:
//   clk, rst (async high)
//   in_valid/in_ready/in_ctrl/in_data   upstream handshake + buses
//   flush                               sync kill of all held entries
//   out_valid/out_ready/out_ctrl/out_data downstream handshake + buses
//   stall_cnt, clr_cnt                  out_valid && !out_ready cycle count
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 256,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_fire, out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = main_valid;
  // Bubbles carry zero control so downstream write enables stay quiet.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e       state, state_nxt;
      logic              rdy_q;
      logic              ld_main_in, ld_main_skid, ld_skid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          state <= state_nxt;
          // in_ready comes straight from a flop: no out_ready->in_ready path.
          rdy_q <= (state_nxt != TWO);
        end
      end

      always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
          state_nxt = EMPTY;
        end else begin
          case (state)
            EMPTY: if (in_fire) begin
              ld_main_in = 1'b1;
              state_nxt  = ONE;
            end
            ONE: begin
              if (in_fire && out_fire) begin
                ld_main_in = 1'b1;
              end else if (in_fire) begin
                ld_skid    = 1'b1;
                state_nxt  = TWO;
              end else if (out_fire) begin
                state_nxt  = EMPTY;
              end
            end
            TWO: if (out_fire) begin
              // skid holds the younger entry; it becomes the head
              ld_main_skid = 1'b1;
              state_nxt    = ONE;
            end
            default: state_nxt = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_ctrl <= '0;
          main_data <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
        end else begin
          if (ld_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (ld_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
          if (ld_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end
        end
      end

      assign main_valid = (state != EMPTY);
      assign in_ready   = rdy_q;
    end else begin : g_reg
      assign in_ready = out_ready || !main_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (in_fire) begin
          main_valid <= 1'b1;
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
        end else if (out_fire) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .clr (clr_cnt),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 instance (16-bit counter) and one
// SKID=0 instance (4-bit counter) driven by the same stimulus, each
// compared against a queue model of its capacity.
module tb_pipe_stage_reg;
  localparam int CW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, flush, out_ready, clr_cnt;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          a_ir, a_ov, b_ir, b_ov;
  logic [CW-1:0] a_oc, b_oc;
  logic [DW-1:0] a_od, b_od;
  logic [15:0]   a_cnt;
  logic [3:0]    b_cnt;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(a_ov), .out_ready(out_ready), .out_ctrl(a_oc),
    .out_data(a_od), .stall_cnt(a_cnt), .clr_cnt(clr_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(b_ov), .out_ready(out_ready), .out_ctrl(b_oc),
    .out_data(b_od), .stall_cnt(b_cnt), .clr_cnt(clr_cnt));

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t qa[$], qb[$];
  int    cnt_a, cnt_b;
  int    n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model view before the edge: head of queue is what out_* must show.
  task automatic check_outputs();
    chk("a.out_valid", a_ov, qa.size() > 0);
    chk("a.in_ready",  a_ir, qa.size() < 2);
    chk("a.out_ctrl",  a_oc, qa.size() > 0 ? qa[0].c : '0);
    if (qa.size() > 0) chk("a.out_data", a_od, qa[0].d);
    chk("a.stall_cnt", a_cnt, cnt_a);
    chk("b.out_valid", b_ov, qb.size() > 0);
    chk("b.in_ready",  b_ir, out_ready || qb.size() == 0);
    chk("b.out_ctrl",  b_oc, qb.size() > 0 ? qb[0].c : '0);
    if (qb.size() > 0) chk("b.out_data", b_od, qb[0].d);
    chk("b.stall_cnt", b_cnt, cnt_b);
  endtask

  task automatic model_edge();
    bit a_in, a_out, b_in, b_out;
    a_in  = in_valid && qa.size() < 2;
    a_out = qa.size() > 0 && out_ready;
    b_in  = in_valid && (out_ready || qb.size() == 0);
    b_out = qb.size() > 0 && out_ready;
    if (clr_cnt) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (qa.size() > 0 && !out_ready && cnt_a < 65535) cnt_a++;
      if (qb.size() > 0 && !out_ready && cnt_b < 15)    cnt_b++;
    end
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out) void'(qa.pop_front());
      if (a_in)  qa.push_back(item_t'{in_ctrl, in_data});
      if (b_out) void'(qb.pop_front());
      if (b_in)  qb.push_back(item_t'{in_ctrl, in_data});
    end
  endtask

  // One clock: drive on negedge, check, then advance the model at posedge.
  task automatic step(input logic r, input logic iv, input logic [CW-1:0] ic,
                      input logic [DW-1:0] id, input logic orr,
                      input logic fl, input logic cc);
    @(negedge clk);
    rst = r; in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = orr; flush = fl; clr_cnt = cc;
    if (r) begin
      qa.delete(); qb.delete();
      cnt_a = 0; cnt_b = 0;
    end
    #1;
    check_outputs();
    @(posedge clk);
    if (!r) model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    cnt_a = 0; cnt_b = 0;

    // reset state
    step(1, 0, '0, '0, 0, 0, 0);
    step(1, 1, 12'hFFF, 32'hDEAD, 1, 0, 0);
    chk("rst.a_data", a_od, 0);
    chk("rst.b_data", b_od, 0);
    chk("rst.a_ready", a_ir, 1);

    // stream 1..8 at full rate
    for (int k = 1; k <= 8; k++) step(0, 1, 12'hFFF, k, 1, 0, 0);
    step(0, 0, '0, '0, 1, 0, 0);
    chk("stream.cnt", a_cnt, 0);

    // back-pressure: A, B accepted by skid, C held upstream, then drain
    step(0, 1, 12'h00A, 32'hA, 0, 0, 0);
    step(0, 1, 12'h00B, 32'hB, 0, 0, 0);
    chk("bp.a_ready_after_B", a_ir, 0);
    step(0, 1, 12'h00C, 32'hC, 0, 0, 0);
    step(0, 1, 12'h00C, 32'hC, 1, 0, 0);
    step(0, 1, 12'h00C, 32'hC, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, '0, '0, 1, 0, 0);

    // flush while holding two entries; C must vanish
    step(0, 1, 12'h0AA, 32'hAA, 0, 0, 0);
    step(0, 1, 12'h0BB, 32'hBB, 0, 0, 0);
    step(0, 1, 12'h0CC, 32'hCC, 0, 1, 0);
    chk("flush.a_valid", a_ov, 0);
    chk("flush.a_ctrl",  a_oc, 0);
    chk("flush.a_ready", a_ir, 1);
    for (int k = 0; k < 3; k++) step(0, 0, '0, '0, 1, 0, 0);

    // bubbles with a dirty ctrl bus
    for (int k = 0; k < 3; k++) step(0, 0, 12'hFFF, 32'h5, k[0], 0, 0);

    // SKID=0 stall: in_ready drops with out_ready, data holds
    step(0, 1, 12'h0D0, 32'hD0, 1, 0, 0);
    step(0, 1, 12'h0E0, 32'hE0, 0, 0, 0);
    chk("s0.in_ready_stall", b_ir, 0);
    chk("s0.data_held", b_od, 32'hD0);
    step(0, 1, 12'h0E0, 32'hE0, 1, 0, 0);
    chk("s0.new_data", b_od, 32'hE0);

    // 4-bit counter saturation then clear
    for (int k = 0; k < 20; k++) step(0, 0, '0, '0, 0, 0, 0);
    chk("sat.full", b_cnt, 4'hF);
    step(0, 0, '0, '0, 0, 0, 1);
    chk("sat.clr", b_cnt, 0);
    step(0, 0, '0, '0, 0, 0, 0);
    chk("sat.reinc", b_cnt, 1);

    // random traffic including flush, clear and mid-run reset
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(99) == 0, $urandom_range(9) < 7, CW'($urandom),
           $urandom, $urandom_range(9) < 6, $urandom_range(15) == 0,
           $urandom_range(31) == 0);
    end
    step(0, 0, '0, '0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
